// File: rtl/ifetch_queue_pkg.sv
// Shared types and instruction-field helpers for the instruction prefetch queue.
package ifetch_queue_pkg;

    typedef logic [31:0] word_t;
    typedef logic [29:0] pc_t;
    typedef logic [6:0]  opcode_t;

    localparam opcode_t OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        IFQ_IDLE,
        IFQ_WAIT,
        IFQ_DROP
    } ifq_state_t;

    typedef struct packed {
        word_t inst;
        pc_t   pc;
    } ifq_entry_t;

    function automatic opcode_t ext_opcode(input word_t i);
        return i[6:0];
    endfunction

    // J-type immediate, sign-extended byte offset
    function automatic word_t ext_j_imm(input word_t i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic pc_t jal_target(input pc_t pc, input word_t i);
        return pc + pc_t'(ext_j_imm(i) >> 2);
    endfunction

endpackage

// File: rtl/ifetch_queue_ram.sv
// Entry storage for the prefetch queue: one write port, asynchronous read of the head.
module ifq_ram
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       we,
    input  logic [AW-1:0] waddr,
    input  ifq_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output ifq_entry_t rdata
);

    ifq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ifetch_queue.sv
// DEPTH-entry instruction prefetch FIFO with single outstanding fetch, flush/redirect.
// Optional IFQ_JAL_FOLLOW_EN: fetch follows JAL targets when the JAL is enqueued.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  pc_t                    flush_pc,
    output logic                   mem_req,
    output word_t                  mem_addr,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  word_t                  mem_rdata,
    output logic                   inst_valid,
    output word_t                  inst,
    output pc_t                    inst_pc,
    output opcode_t                inst_opcode,
    input  logic                   deq,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam pc_t           PC_ONE  = pc_t'(1);

    ifq_state_t    state_reg;
    pc_t           fetch_pc_reg;
    pc_t           tag_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic       deq_fire;
    logic       room;
    logic       grant;
    logic       enq;
    logic       wr_en;
    ifq_entry_t wr_entry;
    ifq_entry_t head;

    assign count      = count_reg;
    assign inst_valid = (count_reg != '0);
    assign deq_fire   = deq && inst_valid;

    // A request is only issued when its response is guaranteed a slot.
    assign room     = (count_reg != FULL) || deq_fire;
    assign mem_req  = !rst && !flush && (state_reg == IFQ_IDLE) && room;
    assign mem_addr = {fetch_pc_reg, 2'b00};
    assign grant    = mem_req && mem_gnt;
    assign enq      = (state_reg == IFQ_WAIT) && mem_rvalid;
    assign wr_en    = enq && !flush && !rst;

    assign wr_entry.inst = mem_rdata;
    assign wr_entry.pc   = tag_reg;

    ifq_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_reg),
        .wdata (wr_entry),
        .raddr (rd_ptr_reg),
        .rdata (head)
    );

    assign inst        = head.inst;
    assign inst_pc     = head.pc;
    assign inst_opcode = ext_opcode(head.inst);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IFQ_IDLE;
            fetch_pc_reg <= RESET_PC[31:2];
            tag_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else if (flush) begin
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fetch_pc_reg <= flush_pc;
            // A flush during DROP keeps waiting for the stale response as well.
            state_reg    <= ((state_reg != IFQ_IDLE) && !mem_rvalid) ? IFQ_DROP : IFQ_IDLE;
        end else begin
            unique case (state_reg)
                IFQ_IDLE: begin
                    if (grant) begin
                        tag_reg      <= fetch_pc_reg;
                        fetch_pc_reg <= fetch_pc_reg + PC_ONE;
                        state_reg    <= IFQ_WAIT;
                    end
                end
                IFQ_WAIT: begin
                    if (mem_rvalid) begin
                        state_reg <= IFQ_IDLE;
`ifdef IFQ_JAL_FOLLOW_EN
                        if (ext_opcode(mem_rdata) == OP_JAL) begin
                            fetch_pc_reg <= jal_target(tag_reg, mem_rdata);
                        end
`endif
                    end
                end
                IFQ_DROP: begin
                    if (mem_rvalid) begin
                        state_reg <= IFQ_IDLE;
                    end
                end
                default: state_reg <= IFQ_IDLE;
            endcase

            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (deq_fire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (enq && !deq_fire) begin
                count_reg <= count_reg + CNT_ONE;
            end else if (!enq && deq_fire) begin
                count_reg <= count_reg - CNT_ONE;
            end
        end
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction prefetch queue for the suro-v core. It generalises the datapath's single-entry instruction lookahead (IR loaded either from memory or from the r1 holding register) into a DEPTH-entry FIFO. The queue fetches sequential words ahead of execution, supports flush and redirect on taken branches and jumps, and can optionally follow JAL targets at fetch time. It sits between the instruction memory port and the datapath's IR load path.

## Interface
Parameters:
- DEPTH, 2 — queue entries; power of two, ≥2.
- RESET_PC, 32'h0 — word-aligned fetch address after reset.

Ports:
- clk  in  1  — clock.
- rst  in  1  — reset, synchronous, active-high.
- flush  in  1  — discard all entries and any outstanding fetch; restart at flush_pc.
- flush_pc  in  pc_t  — redirect target (word address).
- mem_req  out  1  — fetch request valid.
- mem_addr  out  word_t  — byte address, equals {fetch_pc, 2'b00}.
- mem_gnt  in  1  — request accepted this cycle.
- mem_rvalid  in  1  — read data valid; arrives ≥1 cycle after grant.
- mem_rdata  in  word_t  — fetched instruction.
- inst_valid  out  1  — head entry valid.
- inst  out  word_t  — head instruction.
- inst_pc  out  pc_t  — head instruction's pc.
- inst_opcode  out  opcode_t  — ext_opcode(inst), used by forward detection.
- deq  in  1  — consumer pops head; ignored when !inst_valid.
- count  out  $clog2(DEPTH)+1  — occupied entries.

## Operation
- Storage: circular buffer of {inst, pc}. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is kept explicitly.
- Fetch FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request granted, data pending.
  - DROP: a flush occurred while in WAIT; the pending response must be discarded.
- IDLE: mem_req=1 iff count + (deq && inst_valid ? -1 : 0) < DEPTH, i.e. a slot is guaranteed for the response. On mem_gnt: tag ← fetch_pc, fetch_pc ← fetch_pc+1, go to WAIT.
- WAIT: mem_req=0. On mem_rvalid: write {mem_rdata, tag}, go to IDLE.
- DROP: mem_req=0. On mem_rvalid: discard the data, go to IDLE.
- At most one outstanding fetch. pc arithmetic is 30-bit and wraps silently.
- flush (highest priority):
  - count←0; pointers←0; fetch_pc←flush_pc.
  - State becomes DROP if in WAIT without mem_rvalid this cycle; otherwise IDLE.
  - A coincident deq, enqueue or grant is ignored.
  - mem_req is forced 0 in the flush cycle.
- deq and enqueue in the same cycle: count unchanged, both pointers advance.
- Full (count==DEPTH): no request is issued. Empty: inst_valid=0; inst, inst_pc and inst_opcode are don't-care.

## Timing
- Reset values: count=0, inst_valid=0, mem_req=0, state=IDLE, fetch_pc=RESET_PC[31:2], pointers=0.
- Best-case latency: request granted in cycle N, rvalid in N+1, inst_valid=1 in N+2.
- Head outputs are registered-state driven: no combinational path from mem_rdata to inst.
- mem_req depends combinationally on deq. mem_addr is stable while mem_req is held low-to-grant.
- With a 1-cycle memory, sustained throughput is one instruction per 2 cycles. DEPTH hides consumer stalls.
- rst mid-fetch: state returns to IDLE immediately. Any late mem_rvalid after reset is ignored (IDLE ignores rvalid).

## Configuration
- IFQ_JAL_FOLLOW_EN defined:
  - On enqueue of an instruction with ext_opcode==OP_JAL, fetch_pc ← tag + ext_j_imm>>2 instead of sequential.
  - A request already granted in the same cycle is impossible, since WAIT blocks requests.
  - The entry is still enqueued so the datapath performs the rd writeback; the datapath must not flush for JAL.
- Undefined: fetch is purely sequential; JAL is redirected by the consumer via flush.

## Structure
- Shared package (alongside opcode_t, pc_t, word_t, ext_opcode, ext_j_imm): ifq_state_t enum {IFQ_IDLE, IFQ_WAIT, IFQ_DROP}.
- One sub-module: ifq_ram — DEPTH×(32+30) storage with one write port and one asynchronous read port.

## Test plan
- Reset with RESET_PC=0x100, memory returns 0x00000013 at 1-cycle latency, no deq → first mem_addr=0x100; DEPTH=2 fills with pcs 0x40,0x41; mem_req=0 when full.
- Continuous deq at full → next request issued in the same cycle as deq; inst_pc sequence increments by 1 with no gaps.
- Flush to pc 0x80 while in WAIT, rvalid the next cycle with 0xDEADBEEF → data dropped; next mem_addr=0x200; count=0 until the new response.
- Flush and deq in the same cycle with count=2 → count=0; inst_valid=0 the next cycle.
- With IFQ_JAL_FOLLOW_EN: JAL x1,+16 at pc 0x40 → next mem_addr=0x110, and the JAL entry is enqueued with inst_pc=0x40.
- Memory latency of 3 cycles with DEPTH=4 → never more than one outstanding request; count never exceeds 4.
